conv_window_sequencer: RTL and testbench

Sequences the 3x3 convolver datapath: loads the nine kernel weights, streams raster-order pixels into the three pixel shift-register rows (PSR_0..PSR_2), and flags each cycle in which the PSR window holds a complete 3x3 patch for the multiplier array. It also delays that flag by the multiplier/adder pipeline latency so the downstream accumulator knows when a result is valid. The block sits between the pixel/weight source and the multiplier array, and is the only writer of the weight bank.

---
 rtl/conv_window_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Sequencer for the 3x3 convolver: weight load, raster pixel streaming, window/result flags.
// Optional macro CONV_STRIDE2_EN restricts windows to even (row, col) positions.
module conv_window_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int PIPE_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [DATA_WIDTH-1:0]         w_data,
  output logic [9*DATA_WIDTH-1:0]       weights_flat,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic                          psr_shift,
  output logic                          win_valid,
  output logic                          out_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [$clog2(IMG_HEIGHT)-1:0] row
);

  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int DRW = $clog2(PIPE_LAT + 1) + 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [DRW-1:0] DRN_LAST = DRW'(PIPE_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            w_idx_q, w_idx_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DRW-1:0]        drn_q, drn_d;
  logic                  win_q, win_d;
  logic                  busy_q, done_q, w_ready_q, pix_ready_q;
  logic [PIPE_LAT-1:0]   dly_q;
  logic [DATA_WIDTH-1:0] weights_q [9];
  logic                  w_we_s;
  logic                  psr_shift_s;

  // A pixel at (r, c) closes a 3x3 patch once two full rows and two columns precede it.
  function automatic logic window_hit(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic hit;
    hit = (r >= RW'(2)) && (c >= CW'(2));
`ifdef CONV_STRIDE2_EN
    hit = hit && (r[0] == 1'b0) && (c[0] == 1'b0);
`endif
    return hit;
  endfunction

  assign psr_shift_s = pix_valid & pix_ready_q;

  // Next-state and counter logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    w_idx_d = w_idx_q;
    col_d   = col_q;
    row_d   = row_q;
    drn_d   = drn_q;
    win_d   = 1'b0;
    w_we_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          w_idx_d = 4'd0;
          col_d   = {CW{1'b0}};
          row_d   = {RW{1'b0}};
          drn_d   = {DRW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (w_valid && w_ready_q) begin
          w_we_s  = 1'b1;
          w_idx_d = w_idx_q + 4'd1;
          if (w_idx_q == 4'd8) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_LOAD_W;
          end
        end else begin
          state_d = S_LOAD_W;
        end
      end
      S_STREAM: begin
        if (psr_shift_s) begin
          win_d = window_hit(row_q, col_q);
          if (col_q == COL_LAST) begin
            col_d = {CW{1'b0}};
            if (row_q == ROW_LAST) begin
              row_d   = {RW{1'b0}};
              drn_d   = {DRW{1'b0}};
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        // DRAIN spans PIPE_LAT+1 cycles so the last result leaves the delay line by done.
        if (drn_q == DRN_LAST) begin
          state_d = S_IDLE;
        end else begin
          drn_d = drn_q + DRW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and handshake outputs; outputs are decoded from next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_idx_q     <= 4'd0;
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      drn_q       <= {DRW{1'b0}};
      win_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      pix_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_idx_q     <= w_idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drn_q       <= drn_d;
      win_q       <= win_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DRAIN) && (drn_d == DRN_LAST);
      w_ready_q   <= (state_d == S_LOAD_W);
      pix_ready_q <= (state_d == S_STREAM);
    end
  end

  // Result-valid delay line matching the multiplier/adder pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= {PIPE_LAT{1'b0}};
    end else begin
      dly_q[0] <= win_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Weight bank; only written while loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        weights_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_we_s) begin
      weights_q[w_idx_q] <= w_data;
    end else begin
      for (int i = 0; i < 9; i++) begin
        weights_q[i] <= weights_q[i];
      end
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_flat
    assign weights_flat[g*DATA_WIDTH +: DATA_WIDTH] = weights_q[g];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_ready   = w_ready_q;
  assign pix_ready = pix_ready_q;
  assign psr_shift = psr_shift_s;
  assign win_valid = win_q;
  assign out_valid = dly_q[PIPE_LAT-1];
  assign col       = col_q;
  assign row       = row_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: stimulus predicts event cycles, a monitor pops and compares.
module tb_conv_window_sequencer;
  localparam int DW = 32;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PL = 2;
`ifdef CONV_STRIDE2_EN
  localparam int NWIN = ((W - 1) / 2) * ((H - 1) / 2);
`else
  localparam int NWIN = (W - 2) * (H - 2);
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic w_valid = 1'b0;
  logic pix_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic busy, done, w_ready, pix_ready, psr_shift, win_valid, out_valid;
  logic [9*DW-1:0] weights_flat;
  logic [$clog2(W)-1:0] col;
  logic [$clog2(H)-1:0] row;

  conv_window_sequencer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .weights_flat(weights_flat),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .psr_shift(psr_shift),
    .win_valid(win_valid), .out_valid(out_valid), .col(col), .row(row)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int win_q[$];
  int out_q[$];
  int done_q[$];
  int win_cnt, out_cnt, done_cnt, shift_cnt;
  logic [DW-1:0] wexp [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every event must occur on the cycle the model predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_exclusive", {63'd0, w_ready & pix_ready}, 64'd0);
      check("psr_shift_comb", {63'd0, psr_shift}, {63'd0, pix_valid & pix_ready});
      if (psr_shift) shift_cnt++;
      if (win_valid) begin
        win_cnt++;
        check("win_cycle", cyc, (win_q.size() > 0) ? win_q.pop_front() : -1);
      end
      if (out_valid) begin
        out_cnt++;
        check("out_cycle", cyc, (out_q.size() > 0) ? out_q.pop_front() : -1);
      end
      if (done) begin
        done_cnt++;
        check("done_cycle", cyc, (done_q.size() > 0) ? done_q.pop_front() : -1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_w_ready"}, {63'd0, w_ready}, 64'd0);
    check({tag, "_pix_ready"}, {63'd0, pix_ready}, 64'd0);
    check({tag, "_win_valid"}, {63'd0, win_valid}, 64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_col"}, {61'd0, col}, 64'd0);
    check({tag, "_row"}, {61'd0, row}, 64'd0);
    check({tag, "_weights_or"}, {63'd0, |weights_flat}, 64'd0);
  endtask

  task automatic begin_frame();
    win_cnt = 0; out_cnt = 0; done_cnt = 0; shift_cnt = 0;
    win_q.delete(); out_q.delete(); done_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_w_ready", {63'd0, w_ready}, 64'd1);
    check("start_busy", {63'd0, busy}, 64'd1);
  endtask

  task automatic load_weights(input bit gaps);
    for (int i = 0; i < 9; i++) begin
      w_valid = 1'b1;
      w_data  = wexp[i];
      @(negedge clk);
      w_valid = 1'b0;
      if (gaps) @(negedge clk);
    end
    for (int i = 0; i < 9; i++)
      check($sformatf("weight_%0d", i), {32'd0, weights_flat[i*DW +: DW]}, {32'd0, wexp[i]});
    check("stream_pix_ready", {63'd0, pix_ready}, 64'd1);
    check("stream_w_ready", {63'd0, w_ready}, 64'd0);
  endtask

  // mode 0: always valid; 1: valid low every third cycle plus stray start; 2: random stalls.
  task automatic stream_frame(input int mode, input int reset_at);
    int k = 0;
    int budget = 0;
    int r, c, p;
    bit win;
    while (k < W * H && budget < 2000) begin
      case (mode)
        0: pix_valid = 1'b1;
        1: pix_valid = (budget % 3) != 2;
        default: pix_valid = $urandom_range(0, 3) != 0;
      endcase
      start = (mode == 1) && ($urandom_range(0, 3) == 0);
      if (pix_valid && pix_ready) begin
        r = k / W;
        c = k % W;
        check("col_model", {61'd0, col}, c);
        check("row_model", {61'd0, row}, r);
        p = cyc + 1;
        win = (r >= 2) && (c >= 2);
`ifdef CONV_STRIDE2_EN
        win = win && (r % 2 == 0) && (c % 2 == 0);
`endif
        if (win) begin
          win_q.push_back(p);
          out_q.push_back(p + PL);
        end
        if (k == W * H - 1) done_q.push_back(p + PL);
        k++;
        if (k == reset_at) begin
          @(posedge clk);
          #1;
          pix_valid = 1'b0;
          start = 1'b0;
          win_q.delete(); out_q.delete(); done_q.delete();
          rst_n = 1'b0;
          #1;
          check_reset_outputs("midreset");
          return;
        end
      end
      @(negedge clk);
      budget++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    check("pixels_accepted", k, W * H);
  endtask

  task automatic finish_frame(input string tag);
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check({tag, "_windows"}, win_cnt, NWIN);
    check({tag, "_outs"}, out_cnt, NWIN);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_shifts"}, shift_cnt, W * H);
    check({tag, "_pending"}, win_q.size() + out_q.size() + done_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_busy", {63'd0, busy}, 64'd0);
    check("post_reset_w_ready", {63'd0, w_ready}, 64'd0);

    for (int i = 0; i < 9; i++) wexp[i] = DW'(i + 1);
    begin_frame();
    load_weights(1'b1);
    stream_frame(0, -1);
    finish_frame("frame_a");

    for (int i = 0; i < 9; i++) wexp[i] = $urandom;
    begin_frame();
    load_weights(1'b0);
    stream_frame(1, -1);
    finish_frame("frame_b");

    for (int i = 0; i < 9; i++) wexp[i] = $urandom;
    begin_frame();
    load_weights(1'b0);
    stream_frame(2, 13);
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_midreset_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 9; i++) wexp[i] = $urandom;
    begin_frame();
    load_weights(1'b1);
    stream_frame(2, -1);
    finish_frame("frame_d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
